// File: rtl/vend_pkg.sv
// Shared types, coin constants and price-table helper for the vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } vend_state_e;

    localparam int COIN5_UNITS  = 1;
    localparam int COIN10_UNITS = 2;

    // Widest price table supported: 8 products x 16-bit credit.
    localparam int PRICE_VEC_W  = 128;

    function automatic logic [15:0] price_of(input logic [PRICE_VEC_W-1:0] prices,
                                             input int credit_w,
                                             input int idx);
        logic [PRICE_VEC_W-1:0] shifted;
        logic [15:0]            price;
        shifted = prices >> (idx * credit_w);
        price   = 16'd0;
        for (int b = 0; b < 16; b++) begin
            if (b < credit_w) begin
                price[b] = shifted[b];
            end else begin
                price[b] = 1'b0;
            end
        end
        return price;
    endfunction

endpackage

// File: rtl/vend_change_unit.sv
// Change sequencer: loads the credit to refund and pays it out one coin per cycle,
// largest coin first; done is high whenever nothing remains to be paid.
module vend_change_unit
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [CREDIT_W-1:0] load_credit,
    output logic                change5,
    output logic                change10,
    output logic [CREDIT_W-1:0] remaining,
    output logic                done
);

    logic [CREDIT_W-1:0] rem_r;
    logic                change5_r;
    logic                change10_r;

    // Remaining-credit register and one-coin-per-cycle pulse generation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_r      <= '0;
            change5_r  <= 1'b0;
            change10_r <= 1'b0;
        end else if (load) begin
            rem_r      <= load_credit;
            change5_r  <= 1'b0;
            change10_r <= 1'b0;
        end else if (rem_r >= CREDIT_W'(COIN10_UNITS)) begin
            rem_r      <= rem_r - CREDIT_W'(COIN10_UNITS);
            change5_r  <= 1'b0;
            change10_r <= 1'b1;
        end else if (rem_r != '0) begin
            rem_r      <= rem_r - CREDIT_W'(COIN5_UNITS);
            change5_r  <= 1'b1;
            change10_r <= 1'b0;
        end else begin
            change5_r  <= 1'b0;
            change10_r <= 1'b0;
        end
    end

    assign change5   = change5_r;
    assign change10  = change10_r;
    assign remaining = rem_r;
    assign done      = (rem_r == '0);

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine controller: credit accumulation, product selection, dispense and change.
// Define VEND_STOCK_EN to enable per-product stock counters and sold_out reporting.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int                          NUM_PROD   = 4,
    parameter int                          CREDIT_W   = 5,
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES    = {5'd4, 5'd3, 5'd2, 5'd1},
    parameter int                          STOCK_W    = 4,
    parameter int                          STOCK_INIT = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin5,
    input  logic                coin10,
    input  logic [NUM_PROD-1:0] sel,
    input  logic                cancel,
    output logic [NUM_PROD-1:0] dispense,
    output logic                change5,
    output logic                change10,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic [NUM_PROD-1:0] sold_out
);

    localparam int IDX_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;
    localparam logic [CREDIT_W:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

    vend_state_e         state_r, state_n;
    logic [CREDIT_W-1:0] credit_r, credit_n;
    logic [NUM_PROD-1:0] dispense_r, dispense_n;
    logic                reject_r, reject_n;
    logic                busy_r, busy_n;

    logic [CREDIT_W-1:0] price_s [NUM_PROD];
    logic [IDX_W-1:0]    sel_idx_s;
    logic                sel_onehot_s;
    logic                stock_ok_s;
    logic                sel_ok_s;
    logic                vend_go_s;
    logic [CREDIT_W:0]   coin_val_s;
    logic [CREDIT_W:0]   coin_sum_s;
    logic                coin_ok_s;
    logic [CREDIT_W-1:0] base_credit_s;
    logic                chg_load_s;
    logic [CREDIT_W-1:0] chg_val_s;
    logic                chg_done_s;
    logic [CREDIT_W-1:0] chg_rem_s;

    for (genvar g = 0; g < NUM_PROD; g++) begin : g_price
        assign price_s[g] = CREDIT_W'(price_of(PRICE_VEC_W'(PRICES), CREDIT_W, g));
    end

    assign sel_onehot_s = (sel != '0) && ((sel & (sel - NUM_PROD'(1))) == '0);

    // Index of the requested product (meaningful only when sel is one-hot).
    always_comb begin
        sel_idx_s = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (sel[i]) begin
                sel_idx_s = IDX_W'(i);
            end else begin
                sel_idx_s = sel_idx_s;
            end
        end
    end

    // The request is judged on the credit held before any coin of the same cycle.
    assign sel_ok_s  = sel_onehot_s && (credit_r >= price_s[sel_idx_s]) && stock_ok_s;
    assign vend_go_s = (state_r == ST_CREDIT) && !cancel && sel_ok_s;

    assign coin_val_s = coin10 ? (CREDIT_W+1)'(COIN10_UNITS) : (CREDIT_W+1)'(COIN5_UNITS);
    assign coin_sum_s = {1'b0, credit_r} + coin_val_s;
    assign coin_ok_s  = (coin5 ^ coin10)
                     && ((state_r == ST_IDLE) || (state_r == ST_CREDIT))
                     && (coin_sum_s <= CREDIT_MAX);
    assign base_credit_s = coin_ok_s ? coin_sum_s[CREDIT_W-1:0] : credit_r;

`ifdef VEND_STOCK_EN
    logic [STOCK_W-1:0] stock_r [NUM_PROD];

    // Per-product stock, decremented on each accepted selection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PROD; i++) begin
                stock_r[i] <= STOCK_W'(STOCK_INIT);
            end
        end else if (vend_go_s) begin
            stock_r[sel_idx_s] <= stock_r[sel_idx_s] - STOCK_W'(1);
        end
    end

    assign stock_ok_s = (stock_r[sel_idx_s] != '0);

    for (genvar g = 0; g < NUM_PROD; g++) begin : g_sold_out
        assign sold_out[g] = (stock_r[g] == '0);
    end
`else
    // Unlimited stock; the stock parameters only qualify the build configuration.
    assign stock_ok_s = (STOCK_W >= 1) && (STOCK_INIT >= 0);
    assign sold_out   = '0;
`endif

    // Next-state, next-credit and next-output logic.
    always_comb begin
        state_n    = state_r;
        credit_n   = credit_r;
        dispense_n = '0;
        reject_n   = (coin5 | coin10) & ~coin_ok_s;
        chg_load_s = 1'b0;
        chg_val_s  = '0;
        case (state_r)
            ST_IDLE: begin
                if (coin_ok_s) begin
                    credit_n = base_credit_s;
                    state_n  = ST_CREDIT;
                end else begin
                    state_n  = ST_IDLE;
                end
            end
            ST_CREDIT: begin
                if (cancel) begin
                    chg_load_s = 1'b1;
                    chg_val_s  = base_credit_s;
                    credit_n   = '0;
                    state_n    = ST_CHANGE;
                end else if (vend_go_s) begin
                    dispense_n = sel;
                    credit_n   = base_credit_s - price_s[sel_idx_s];
                    state_n    = ST_VEND;
                end else begin
                    credit_n   = base_credit_s;
                    state_n    = ST_CREDIT;
                end
            end
            ST_VEND: begin
                if (credit_r != '0) begin
                    chg_load_s = 1'b1;
                    chg_val_s  = credit_r;
                    credit_n   = '0;
                    state_n    = ST_CHANGE;
                end else begin
                    state_n    = ST_IDLE;
                end
            end
            ST_CHANGE: begin
                if (chg_done_s) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_CHANGE;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                credit_n = '0;
            end
        endcase
        busy_n = (state_n == ST_VEND) || (state_n == ST_CHANGE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            credit_r   <= '0;
            dispense_r <= '0;
            reject_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            credit_r   <= credit_n;
            dispense_r <= dispense_n;
            reject_r   <= reject_n;
            busy_r     <= busy_n;
        end
    end

    vend_change_unit #(
        .CREDIT_W (CREDIT_W)
    ) u_change (
        .clk         (clk),
        .reset       (reset),
        .load        (chg_load_s),
        .load_credit (chg_val_s),
        .change5     (change5),
        .change10    (change10),
        .remaining   (chg_rem_s),
        .done        (chg_done_s)
    );

    // Credit lives in credit_r until it is handed to the change unit, so one is always zero.
    assign credit      = credit_r | chg_rem_s;
    assign dispense    = dispense_r;
    assign coin_reject = reject_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl (default parameters; honours VEND_STOCK_EN).
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin5 = 1'b0;
    logic       coin10 = 1'b0;
    logic [3:0] sel = 4'd0;
    logic       cancel = 1'b0;
    logic [3:0] dispense;
    logic       change5;
    logic       change10;
    logic       coin_reject;
    logic [4:0] credit;
    logic       busy;
    logic [3:0] sold_out;

    int vec_cnt = 0;
    int miss_cnt = 0;

    vend_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .coin5       (coin5),
        .coin10      (coin10),
        .sel         (sel),
        .cancel      (cancel),
        .dispense    (dispense),
        .change5     (change5),
        .change10    (change10),
        .coin_reject (coin_reject),
        .credit      (credit),
        .busy        (busy),
        .sold_out    (sold_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic c5, input logic c10, input logic [3:0] s, input logic cn);
        coin5 = c5; coin10 = c10; sel = s; cancel = cn;
        @(posedge clk); #1;
        coin5 = 1'b0; coin10 = 1'b0; sel = 4'd0; cancel = 1'b0;
    endtask

    // Run until busy drops, counting change coins and pulse overlaps.
    task automatic drain(input string tag, input int exp10, input int exp5, input logic coin_first);
        int n10 = 0;
        int n5 = 0;
        int both = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(coin_first && (k == 0), 1'b0, 4'd0, 1'b0);
            if (coin_first && (k == 0)) chk({tag, "_busy_reject"}, coin_reject, 32'd1);
            n10 += int'(change10);
            n5  += int'(change5);
            if ((change5 && change10) || ((dispense != 4'd0) && (change5 || change10))) both++;
            if (!busy) break;
        end
        chk({tag, "_idle"}, busy, 32'd0);
        chk({tag, "_n10"}, n10, exp10);
        chk({tag, "_n5"}, n5, exp5);
        chk({tag, "_excl"}, both, 32'd0);
        chk({tag, "_credit0"}, credit, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_credit", credit, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_disp", dispense, 32'd0);
        chk("rst_chg", {change10, change5, coin_reject}, 32'd0);
        chk("rst_sold", sold_out, 32'd0);

        // Rs.10 then product 0 (price 1): dispense, then one Rs.5 back.
        cyc(1'b0, 1'b1, 4'b0000, 1'b0);
        chk("t1_credit", credit, 32'd2);
        cyc(1'b0, 1'b0, 4'b0001, 1'b0);
        chk("t1_disp", dispense, 32'd1);
        chk("t1_credit_v", credit, 32'd1);
        chk("t1_busy", busy, 32'd1);
        drain("t1", 0, 1, 1'b0);

        // Two Rs.10 then product 3 (price 4): exact credit, coin during VEND rejected.
        cyc(1'b0, 1'b1, 4'b0000, 1'b0);
        cyc(1'b0, 1'b1, 4'b0000, 1'b0);
        chk("t2_credit", credit, 32'd4);
        cyc(1'b0, 1'b0, 4'b1000, 1'b0);
        chk("t2_disp", dispense, 32'd8);
        chk("t2_credit_v", credit, 32'd0);
        drain("t2", 0, 0, 1'b1);

        // Insufficient credit for product 2, then cancel.
        cyc(1'b1, 1'b0, 4'b0000, 1'b0);
        cyc(1'b0, 1'b0, 4'b0100, 1'b0);
        chk("t3_ign_disp", dispense, 32'd0);
        chk("t3_ign_credit", credit, 32'd1);
        chk("t3_ign_busy", busy, 32'd0);
        cyc(1'b0, 1'b0, 4'b0000, 1'b1);
        chk("t3_cancel_busy", busy, 32'd1);
        drain("t3", 0, 1, 1'b0);

        // Same-cycle coin is added after the price check.
        cyc(1'b0, 1'b1, 4'b0000, 1'b0);
        cyc(1'b1, 1'b0, 4'b0010, 1'b0);
        chk("t4_disp", dispense, 32'd2);
        chk("t4_credit", credit, 32'd1);
        drain("t4", 0, 1, 1'b0);
        cyc(1'b1, 1'b0, 4'b0000, 1'b0);
        cyc(1'b0, 1'b1, 4'b0100, 1'b0);
        chk("t5_disp", dispense, 32'd0);
        chk("t5_credit", credit, 32'd3);
        cyc(1'b0, 1'b0, 4'b0011, 1'b0);
        chk("t5_multi_disp", dispense, 32'd0);
        chk("t5_multi_credit", credit, 32'd3);
        cyc(1'b0, 1'b0, 4'b0000, 1'b1);
        drain("t5", 1, 1, 1'b0);

        // Credit saturation at 31 and simultaneous coins.
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 4'b0000, 1'b0);
        cyc(1'b1, 1'b0, 4'b0000, 1'b0);
        chk("t6_credit31", credit, 32'd31);
        chk("t6_no_rej", coin_reject, 32'd0);
        cyc(1'b1, 1'b0, 4'b0000, 1'b0);
        chk("t6_ovf_rej", coin_reject, 32'd1);
        chk("t6_ovf_credit", credit, 32'd31);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0);
        chk("t6_rej_pulse", coin_reject, 32'd0);
        cyc(1'b1, 1'b1, 4'b0000, 1'b0);
        chk("t6_both_rej", coin_reject, 32'd1);
        chk("t6_both_credit", credit, 32'd31);
        cyc(1'b0, 1'b0, 4'b0000, 1'b1);
        drain("t6", 15, 1, 1'b1);

        // Cancel beats a valid selection; reset in the middle of change.
        cyc(1'b0, 1'b1, 4'b0000, 1'b0);
        cyc(1'b1, 1'b0, 4'b0000, 1'b0);
        chk("t7_credit", credit, 32'd3);
        cyc(1'b0, 1'b0, 4'b0001, 1'b1);
        chk("t7_no_disp", dispense, 32'd0);
        chk("t7_busy", busy, 32'd1);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0);
        chk("t7_c10", change10, 32'd1);
        chk("t7_credit_rem", credit, 32'd1);
        reset = 1'b1;
        #1;
        chk("t7_rst_chg", {change10, change5}, 32'd0);
        chk("t7_rst_credit", credit, 32'd0);
        chk("t7_rst_busy", busy, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        cyc(1'b0, 1'b0, 4'b0000, 1'b0);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0);
        chk("t7_after_chg", {change10, change5}, 32'd0);
        chk("t7_after_credit", credit, 32'd0);

        // Three vends of product 0 exhaust stock of 3 when stock is enabled.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 4'b0000, 1'b0);
            cyc(1'b0, 1'b0, 4'b0001, 1'b0);
            chk("t8_disp", dispense, 32'd1);
            drain("t8", 0, 0, 1'b0);
        end
        cyc(1'b1, 1'b0, 4'b0000, 1'b0);
        cyc(1'b0, 1'b0, 4'b0001, 1'b0);
`ifdef VEND_STOCK_EN
        chk("t8_sold", sold_out, 32'd1);
        chk("t8_4th_disp", dispense, 32'd0);
        chk("t8_4th_credit", credit, 32'd1);
        cyc(1'b0, 1'b0, 4'b0000, 1'b1);
        drain("t8_refund", 0, 1, 1'b0);
`else
        chk("t8_sold", sold_out, 32'd0);
        chk("t8_4th_disp", dispense, 32'd1);
        chk("t8_4th_credit", credit, 32'd0);
        drain("t8_last", 0, 0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter NUM_PROD, default 4, number of products (2..8).
REQ-002 Parameter CREDIT_W, default 5, credit width in Rs.5 units.
REQ-003 Parameter PRICES, default {4,3,2,1} (NUM_PROD*CREDIT_W packed, product 0 in LSBs), per-product price in Rs.5 units.
REQ-004 Parameter STOCK_W, default 4; parameter STOCK_INIT, default 3, per-product stock at reset.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 coin5  input  1  one-cycle pulse, Rs.5 inserted.
REQ-008 coin10  input  1  one-cycle pulse, Rs.10 inserted.
REQ-009 sel  input  NUM_PROD  product request, one-hot, sampled each cycle.
REQ-010 cancel  input  1  one-cycle pulse, refund request.
REQ-011 dispense  output  NUM_PROD  one-cycle one-hot pulse, product released.
REQ-012 change5 / change10  output  1 each  one-cycle pulse per returned coin.
REQ-013 coin_reject  output  1  one-cycle pulse, inserted coin returned unaccepted.
REQ-014 credit  output  CREDIT_W  current credit in Rs.5 units.
REQ-015 busy  output  1  high in VEND and CHANGE.
REQ-016 sold_out  output  NUM_PROD  bit i high when stock[i]==0.

Function
REQ-017 FSM states IDLE, CREDIT, VEND, CHANGE; registered outputs.
REQ-018 IDLE/CREDIT: coin5 adds 1, coin10 adds 2; IDLE->CREDIT on first accepted coin.
REQ-019 Coin SHALL be rejected (coin_reject next cycle, credit unchanged) if credit+value > 2^CREDIT_W-1, if coin5 and coin10 both high, or if state is VEND/CHANGE.
REQ-020 In CREDIT, sel accepted only if exactly one bit set, credit >= price, stock > 0; otherwise ignored, no state change.
REQ-021 sel evaluated against credit before any same-cycle coin; same-cycle coin still added.
REQ-022 sel accepted in cycle N -> dispense[i] high in cycle N+1 (state VEND), stock[i] decremented, credit -= price.
REQ-023 VEND -> CHANGE if remaining credit > 0, else -> IDLE.
REQ-024 CHANGE: one coin per cycle; change10 while credit >= 2, else change5; credit decrements accordingly; -> IDLE when credit reaches 0.
REQ-025 cancel in CREDIT -> CHANGE, full credit refunded per REQ-024; cancel in IDLE/VEND/CHANGE ignored.
REQ-026 cancel and valid sel in same cycle: cancel wins, no dispense.
REQ-027 Never more than one of dispense/change5/change10 asserted in a cycle.

Reset
REQ-028 On reset: state IDLE, credit 0, all pulse outputs 0, busy 0, stock[i]=STOCK_INIT.
REQ-029 Reset during VEND/CHANGE discards remaining credit; no further pulses.

Configuration
REQ-030 Macro VEND_STOCK_EN defined: per-product stock counters, sold_out driven, empty product's sel ignored.
REQ-031 VEND_STOCK_EN undefined: no stock counters, stock unlimited, sold_out tied 0, STOCK_W/STOCK_INIT unused.

Structure
REQ-032 Package vend_pkg holds state enum, coin-value constants (COIN5_UNITS=1, COIN10_UNITS=2), price-extract function.
REQ-033 Sub-module vend_change_unit implements REQ-024 change sequencing (load credit, emit pulses, done flag).

Verification
REQ-034 coin10, sel[0] (price 1) -> dispense=0001 next cycle, then one change5, credit 0, IDLE.
REQ-035 coin10 x2, sel[3] (price 4) -> dispense=1000, no change pulses, credit 0.
REQ-036 coin5, sel[2] (price 3) -> ignored, credit stays 1; cancel -> one change5, IDLE.
REQ-037 Credit 31 (CREDIT_W=5), coin5 -> coin_reject, credit 31; coin5+coin10 same cycle -> coin_reject.
REQ-038 VEND_STOCK_EN: 3 vends of product 0 -> sold_out[0]=1; 4th sel[0] ignored, credit retained.
REQ-039 Credit 3 plus sel[0] plus cancel same cycle -> no dispense; change10 then change5; reset asserted mid-CHANGE -> pulses stop, credit 0.
